// File: rtl/writeback_ports_pkg.sv
// rtl/writeback_ports_pkg.sv - shared widths, write request type and rd match helper
package writeback_ports_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    value;
  } wb_req_t;

  // True when either live lane write targets rd; such a lane write is younger than any queued result.
  function automatic logic rd_hit(input logic [REG_IDX_W-1:0] rd, input wb_req_t a, input wb_req_t b);
    return (a.valid && (a.rd == rd)) || (b.valid && (b.rd == rd));
  endfunction

endpackage

// File: rtl/writeback_ports_if.sv
// rtl/writeback_ports_if.sv - lane, late-result and register file write port bundle
interface writeback_ports_if;
  import writeback_ports_pkg::*;

  logic                 lane0_valid_i;
  logic [REG_IDX_W-1:0] lane0_rd_i;
  logic [DATA_W-1:0]    lane0_value_i;
  logic                 lane1_valid_i;
  logic [REG_IDX_W-1:0] lane1_rd_i;
  logic [DATA_W-1:0]    lane1_value_i;
  logic                 late_valid_i;
  logic [REG_IDX_W-1:0] late_rd_i;
  logic [DATA_W-1:0]    late_value_i;
  logic                 late_ready_o;
  logic [REG_IDX_W-1:0] rd0_o;
  logic [DATA_W-1:0]    rd0_value_o;
  logic [REG_IDX_W-1:0] rd1_o;
  logic [DATA_W-1:0]    rd1_value_o;
  logic [2:0]           late_level_o;
  logic                 late_squash_o;

  modport master (
    output lane0_valid_i, lane0_rd_i, lane0_value_i,
    output lane1_valid_i, lane1_rd_i, lane1_value_i,
    output late_valid_i, late_rd_i, late_value_i,
    input  late_ready_o, rd0_o, rd0_value_o, rd1_o, rd1_value_o,
    input  late_level_o, late_squash_o
  );

  modport slave (
    input  lane0_valid_i, lane0_rd_i, lane0_value_i,
    input  lane1_valid_i, lane1_rd_i, lane1_value_i,
    input  late_valid_i, late_rd_i, late_value_i,
    output late_ready_o, rd0_o, rd0_value_o, rd1_o, rd1_value_o,
    output late_level_o, late_squash_o
  );

endinterface

// File: rtl/writeback_ports_late_queue.sv
// rtl/writeback_ports_late_queue.sv - ordered late-result queue with kill, compaction and 2-wide drain
module wb_late_queue
  import writeback_ports_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  wb_req_t    push_i,
  output logic       ready_o,
  input  wb_req_t    kill0_i,
  input  wb_req_t    kill1_i,
  input  logic [1:0] free_cnt_i,
  output wb_req_t    drain0_o,
  output wb_req_t    drain1_o,
  output logic [2:0] level_o,
  output logic       squash_o
);

  wb_req_t    slot_q [DEPTH];
  wb_req_t    slot_d [DEPTH];
  logic [2:0] level_q, level_d;
  logic       squash_q, squash_d;

  wb_req_t    surv [8];
  logic [2:0] surv_cnt;
  logic [2:0] pop_cnt;
  logic [2:0] remain;
  logic       killed;
  logic       take0, take1, dup;
  logic       push_acc, push_kill, push_en;

  assign ready_o  = rst_i && (level_q < 3'(DEPTH));
  assign level_o  = level_q;
  assign squash_o = squash_q;

  always_comb begin
    surv     = '{default: '0};
    surv_cnt = 3'd0;
    killed   = 1'b0;
    // Survivors are packed oldest-first so slot 0 stays the oldest after the edge.
    for (int i = 0; i < DEPTH; i++) begin
      if (3'(i) < level_q) begin
        if (rd_hit(slot_q[i].rd, kill0_i, kill1_i)) begin
          killed = 1'b1;
        end else begin
          surv[surv_cnt] = slot_q[i];
          surv_cnt       = surv_cnt + 3'd1;
        end
      end
    end

    take0 = (surv_cnt != 3'd0) && (free_cnt_i != 2'd0);
    take1 = (surv_cnt > 3'd1) && (free_cnt_i == 2'd2);
    dup   = take1 && (surv[0].rd == surv[1].rd);

    drain0_o = '0;
    drain1_o = '0;
    if (dup) begin
      drain0_o = surv[1];
    end else begin
      if (take0) drain0_o = surv[0];
      if (take1) drain1_o = surv[1];
    end

    pop_cnt = {2'b00, take0} + {2'b00, take1};
    remain  = surv_cnt - pop_cnt;

    // x0 results are consumed without queueing; lane-matched ones are already stale.
    push_acc  = push_i.valid && ready_o && (push_i.rd != REG_ZERO);
    push_kill = push_acc && rd_hit(push_i.rd, kill0_i, kill1_i);
    push_en   = push_acc && !push_kill;

    for (int j = 0; j < DEPTH; j++) begin
      slot_d[j] = '0;
      if (3'(j) < remain) begin
        slot_d[j] = surv[3'(j) + pop_cnt];
      end else if (push_en && (3'(j) == remain)) begin
        slot_d[j] = push_i;
      end
    end

    level_d  = remain + {2'b00, push_en};
    squash_d = killed || push_kill || dup;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      slot_q   <= '{default: '0};
      level_q  <= 3'd0;
      squash_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      level_q  <= level_d;
      squash_q <= squash_d;
    end
  end

endmodule

// File: rtl/writeback_ports.sv
// rtl/writeback_ports.sv - merges two issue lanes and the late queue onto registered rd0/rd1 write ports
module writeback_ports
  import writeback_ports_pkg::*;
#(
  parameter int LATE_DEPTH         = 2,
  parameter bit SUPPORT_DUAL_ISSUE = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  writeback_ports_if.slave wb
);

  wb_req_t lane0, lane1, late_in;
  wb_req_t drain0, drain1;
  wb_req_t port0, port1;
  logic    lane0_live, lane1_live, lane0_keep;
  logic [1:0] free_cnt;
  logic    late_ready;
  logic [2:0] late_level;
  logic    late_squash;

  logic [REG_IDX_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_W-1:0]    rd0_value_q, rd0_value_d, rd1_value_q, rd1_value_d;

  always_comb begin
    lane0_live = wb.lane0_valid_i && (wb.lane0_rd_i != REG_ZERO);
    lane1_live = SUPPORT_DUAL_ISSUE && wb.lane1_valid_i && (wb.lane1_rd_i != REG_ZERO);
    lane0      = {lane0_live, wb.lane0_rd_i, wb.lane0_value_i};
    lane1      = {lane1_live, wb.lane1_rd_i, wb.lane1_value_i};
    late_in    = {wb.late_valid_i, wb.late_rd_i, wb.late_value_i};
    // Same-rd lanes: lane1 is younger, so lane0 is dropped and port 0 opens up for a drain.
    lane0_keep = lane0_live && !(lane1_live && (wb.lane0_rd_i == wb.lane1_rd_i));
    free_cnt   = {1'b0, !lane0_keep} + {1'b0, !lane1_live};
  end

  wb_late_queue #(
    .DEPTH (LATE_DEPTH)
  ) u_late_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (late_in),
    .ready_o    (late_ready),
    .kill0_i    (lane0),
    .kill1_i    (lane1),
    .free_cnt_i (free_cnt),
    .drain0_o   (drain0),
    .drain1_o   (drain1),
    .level_o    (late_level),
    .squash_o   (late_squash)
  );

  always_comb begin
    // drain0 always goes to the first free port, drain1 only when both are free.
    port0 = lane0_keep ? lane0 : drain0;
    port1 = lane1_live ? lane1 : (lane0_keep ? drain0 : drain1);

    rd0_d       = port0.valid ? port0.rd    : REG_ZERO;
    rd0_value_d = port0.valid ? port0.value : '0;
    rd1_d       = port1.valid ? port1.rd    : REG_ZERO;
    rd1_value_d = port1.valid ? port1.value : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd0_q       <= REG_ZERO;
      rd0_value_q <= '0;
      rd1_q       <= REG_ZERO;
      rd1_value_q <= '0;
    end else begin
      rd0_q       <= rd0_d;
      rd0_value_q <= rd0_value_d;
      rd1_q       <= rd1_d;
      rd1_value_q <= rd1_value_d;
    end
  end

  assign wb.rd0_o         = rd0_q;
  assign wb.rd0_value_o   = rd0_value_q;
  assign wb.rd1_o         = rd1_q;
  assign wb.rd1_value_o   = rd1_value_q;
  assign wb.late_ready_o  = late_ready;
  assign wb.late_level_o  = late_level;
  assign wb.late_squash_o = late_squash;

endmodule

// File: tb/tb_writeback_ports.sv
// tb/tb_writeback_ports.sv - directed self-checking bench for writeback_ports
module tb_writeback_ports;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  writeback_ports_if wb_if();

  writeback_ports #(
    .LATE_DEPTH         (2),
    .SUPPORT_DUAL_ISSUE (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ports(input string tag, input logic [4:0] r0, input logic [31:0] v0,
                           input logic [4:0] r1, input logic [31:0] v1);
    chk({tag, ".rd0"}, 32'(wb_if.rd0_o), 32'(r0));
    chk({tag, ".val0"}, wb_if.rd0_value_o, v0);
    chk({tag, ".rd1"}, 32'(wb_if.rd1_o), 32'(r1));
    chk({tag, ".val1"}, wb_if.rd1_value_o, v1);
  endtask

  task automatic lanes(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    wb_if.lane0_valid_i = v0; wb_if.lane0_rd_i = r0; wb_if.lane0_value_i = d0;
    wb_if.lane1_valid_i = v1; wb_if.lane1_rd_i = r1; wb_if.lane1_value_i = d1;
  endtask

  task automatic late(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_if.late_valid_i = v; wb_if.late_rd_i = r; wb_if.late_value_i = d;
  endtask

  initial begin
    lanes(0, 0, 0, 0, 0, 0);
    late(1, 5'd9, 32'h99);
    rst = 1'b0;

    // Reset held with a late offer present
    step();
    chk("rst1.ready", 32'(wb_if.late_ready_o), 0);
    chk_ports("rst1", 0, 0, 0, 0);
    chk("rst1.level", 32'(wb_if.late_level_o), 0);
    chk("rst1.squash", 32'(wb_if.late_squash_o), 0);
    step();
    chk("rst2.ready", 32'(wb_if.late_ready_o), 0);
    chk("rst2.level", 32'(wb_if.late_level_o), 0);

    rst = 1'b1;
    late(0, 0, 0);
    step();
    chk("rel.ready", 32'(wb_if.late_ready_o), 1);
    chk("rel.level", 32'(wb_if.late_level_o), 0);
    chk_ports("rel", 0, 0, 0, 0);

    // Lane path
    lanes(1, 5'd5, 32'h11, 1, 5'd7, 32'h22);
    step();
    chk_ports("lanes", 5'd5, 32'h11, 5'd7, 32'h22);

    // Same-rd lanes: only lane1 written
    lanes(1, 5'd3, 32'hA, 1, 5'd3, 32'hB);
    step();
    chk_ports("samerd", 0, 0, 5'd3, 32'hB);

    // Lane to x0 is discarded
    lanes(1, 5'd0, 32'h77, 0, 0, 0);
    step();
    chk_ports("x0lane", 0, 0, 0, 0);

    // Fill the queue while both ports are busy
    lanes(1, 5'd1, 32'h101, 1, 5'd2, 32'h202);
    late(1, 5'd9, 32'h99);
    step();
    chk("fill1.level", 32'(wb_if.late_level_o), 1);
    chk("fill1.ready", 32'(wb_if.late_ready_o), 1);
    late(1, 5'd10, 32'hAA);
    step();
    chk("fill2.level", 32'(wb_if.late_level_o), 2);
    chk("fill2.ready", 32'(wb_if.late_ready_o), 0);
    chk_ports("fill2", 5'd1, 32'h101, 5'd2, 32'h202);

    lanes(0, 0, 0, 0, 0, 0);
    late(0, 0, 0);
    step();
    chk_ports("drain2", 5'd9, 32'h99, 5'd10, 32'hAA);
    chk("drain2.level", 32'(wb_if.late_level_o), 0);
    chk("drain2.ready", 32'(wb_if.late_ready_o), 1);
    step();
    chk_ports("idle", 0, 0, 0, 0);

    // Squash a queued entry with a younger lane1 write
    lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd12, 32'hDEAD);
    step();
    chk("sq.push.level", 32'(wb_if.late_level_o), 1);
    lanes(0, 0, 0, 1, 5'd12, 32'hBEEF);
    late(0, 0, 0);
    step();
    chk_ports("sq", 0, 0, 5'd12, 32'hBEEF);
    chk("sq.squash", 32'(wb_if.late_squash_o), 1);
    chk("sq.level", 32'(wb_if.late_level_o), 0);
    lanes(0, 0, 0, 0, 0, 0);
    step();
    chk_ports("sq.after", 0, 0, 0, 0);
    chk("sq.after.squash", 32'(wb_if.late_squash_o), 0);

    // Single free port: the drained entry lands on port 1
    lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd15, 32'h15);
    step();
    lanes(1, 5'd4, 32'h44, 0, 0, 0);
    late(0, 0, 0);
    step();
    chk_ports("onefree", 5'd4, 32'h44, 5'd15, 32'h15);
    chk("onefree.level", 32'(wb_if.late_level_o), 0);

    // Two queued entries with the same rd: only the younger is written
    lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd14, 32'h141);
    step();
    late(1, 5'd14, 32'h142);
    step();
    chk("dup.level", 32'(wb_if.late_level_o), 2);
    lanes(0, 0, 0, 0, 0, 0);
    late(0, 0, 0);
    step();
    chk_ports("dup", 5'd14, 32'h142, 0, 0);
    chk("dup.squash", 32'(wb_if.late_squash_o), 1);
    chk("dup.level", 32'(wb_if.late_level_o), 0);

    // Late result to x0 is consumed without a level change
    late(1, 5'd0, 32'h55);
    #1;
    chk("x0late.ready", 32'(wb_if.late_ready_o), 1);
    step();
    chk("x0late.level", 32'(wb_if.late_level_o), 0);
    late(0, 0, 0);
    step();
    chk_ports("x0late", 0, 0, 0, 0);

    // Reset with two entries queued discards them
    lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd20, 32'h20);
    step();
    late(1, 5'd21, 32'h21);
    step();
    chk("mid.level", 32'(wb_if.late_level_o), 2);
    lanes(0, 0, 0, 0, 0, 0);
    late(0, 0, 0);
    rst = 1'b0;
    step();
    chk("mid.rst.level", 32'(wb_if.late_level_o), 0);
    chk_ports("mid.rst", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk_ports("mid.rel1", 0, 0, 0, 0);
    chk("mid.rel1.level", 32'(wb_if.late_level_o), 0);
    step();
    chk_ports("mid.rel2", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
